// File: rtl/pulse_event_queue_pkg.sv
// Shared state encoding and default sizing for the pulse event queue.
// Encoding 2'd3 is unused and the FSM recovers from it to IDLE.
package pulse_q_pkg;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_HI = 2'd1;
  localparam logic [1:0] ST_WAIT_LO = 2'd2;

  localparam int CNT_W_DEF   = 4;
  localparam int TIMEOUT_DEF = 64;
  localparam int TO_W_DEF    = 7;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    WAIT_HI = ST_WAIT_HI,
    WAIT_LO = ST_WAIT_LO
  } state_e;
endpackage

// File: rtl/pulse_event_queue_if.sv
// Event/handshake bundle between the event source, the synchronizer and the queue.
interface pulse_event_queue_if #(parameter int CNT_W = 4);
  logic             ev_in;
  logic             sync_ack;
  logic             ovf_clr;
  logic             to_clr;
  logic             sync_req;
  logic [CNT_W-1:0] pending;
  logic             busy;
  logic             ovf;
  logic             to_err;

  modport master (
    output ev_in, sync_ack, ovf_clr, to_clr,
    input  sync_req, pending, busy, ovf, to_err
  );

  modport slave (
    input  ev_in, sync_ack, ovf_clr, to_clr,
    output sync_req, pending, busy, ovf, to_err
  );
endinterface

// File: rtl/pulse_event_queue_pend_sat_cnt.sv
// Saturating up/down counter of pending events; a simultaneous inc and dec cancel.
module pend_sat_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_full,
  output logic         o_empty,
  output logic         o_ovf_pulse
);
  logic [W-1:0] r_cnt;

  assign o_cnt       = r_cnt;
  assign o_full      = &r_cnt;
  assign o_empty     = ~|r_cnt;
  // An increment is only lost when full and nothing leaves in the same cycle.
  assign o_ovf_pulse = i_inc & ~i_dec & o_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec && !o_full) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (i_dec && !i_inc && !o_empty) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/pulse_event_queue.sv
// Source-side event queue: issues one sync_req per pending event and waits for a
// full high-then-low acknowledge before the next; flags overflow and ack timeout.
module pulse_event_queue
  import pulse_q_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = TO_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pulse_event_queue_if.slave   bus
);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_sync_req;
  logic             r_ovf;
  logic             r_to_err;
  logic             w_issue;
  logic             w_to_hit;
  logic             w_full;
  logic             w_empty;
  logic             w_ovf_pulse;
  logic [CNT_W-1:0] w_pending;

  pend_sat_cnt #(.W(CNT_W)) u_pend (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_inc       (bus.ev_in),
    .i_dec       (w_issue),
    .o_cnt       (w_pending),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_ovf_pulse (w_ovf_pulse)
  );

  // A stale acknowledge still high in IDLE blocks the next issue.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_to_hit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty && !bus.sync_ack) begin
          w_issue     = 1'b1;
          w_state_nxt = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (bus.sync_ack) begin
          w_state_nxt = WAIT_LO;
        end else if (r_to_cnt == TO_LAST) begin
          w_to_hit    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      WAIT_LO: begin
        if (!bus.sync_ack) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_to_cnt   <= '0;
      r_sync_req <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sync_req <= w_issue;
      if (w_issue) begin
        r_to_cnt <= '0;
      end else if (r_state == WAIT_HI) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  // Sticky flags: a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf    <= 1'b0;
      r_to_err <= 1'b0;
    end else begin
      if (w_ovf_pulse)      r_ovf <= 1'b1;
      else if (bus.ovf_clr) r_ovf <= 1'b0;
      if (w_to_hit)         r_to_err <= 1'b1;
      else if (bus.to_clr)  r_to_err <= 1'b0;
    end
  end

  ovf_only_when_full: assert property (@(posedge clk) disable iff (!rst_n) w_ovf_pulse |-> w_full);

  assign bus.sync_req = r_sync_req;
  assign bus.pending  = w_pending;
  assign bus.busy     = (r_state != IDLE);
  assign bus.ovf      = r_ovf;
  assign bus.to_err   = r_to_err;
endmodule

// File: tb/tb_pulse_event_queue.sv
// Directed bench for pulse_event_queue: a per-cycle vector table plus
// hand-written burst, overflow, timeout and asynchronous-reset sequences.
module tb_pulse_event_queue;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 64;
  localparam int TO_W    = 7;
  localparam int NVEC    = 31;

  typedef struct {
    logic ev;
    logic ack;
    logic exp_req;
    int   exp_pend;
    logic exp_busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pulse_event_queue_if #(.CNT_W(CNT_W)) bus ();

  pulse_event_queue #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[NVEC];
  int   req_cnt, peak, rise, fall, req_cyc, to_cyc;
  bit   seen_hi, seen_lo;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ev, input logic ack, input logic oc, input logic tc);
    bus.ev_in    = ev;
    bus.sync_ack = ack;
    bus.ovf_clr  = oc;
    bus.to_clr   = tc;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},   int'(bus.sync_req), 0);
    check({tag, "_pend"},  int'(bus.pending),  0);
    check({tag, "_busy"},  int'(bus.busy),     0);
    check({tag, "_ovf"},   int'(bus.ovf),      0);
    check({tag, "_toerr"}, int'(bus.to_err),   0);
  endtask

  function automatic vec_t mk(logic ev, logic ack, logic req, int pend, logic busy);
    vec_t v;
    v.ev = ev; v.ack = ack; v.exp_req = req; v.exp_pend = pend; v.exp_busy = busy;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Single event: ev at 10, ack high 15..19, low from 20.
    for (int i = 0; i < 23; i++)
      vecs[i] = mk(i == 10, (i >= 15) && (i < 20), i == 12, (i == 11) ? 1 : 0, (i >= 12) && (i <= 20));
    // Stale ack holds off issue; then ev coincides with an issue at pending=2.
    vecs[23] = mk(1'b1, 1'b1, 1'b0, 0, 1'b0);
    vecs[24] = mk(1'b1, 1'b1, 1'b0, 1, 1'b0);
    vecs[25] = mk(1'b1, 1'b0, 1'b0, 2, 1'b0);
    vecs[26] = mk(1'b0, 1'b0, 1'b1, 2, 1'b1);
    vecs[27] = mk(1'b0, 1'b1, 1'b0, 2, 1'b1);
    vecs[28] = mk(1'b0, 1'b0, 1'b0, 2, 1'b1);
    vecs[29] = mk(1'b0, 1'b0, 1'b0, 2, 1'b0);
    vecs[30] = mk(1'b0, 1'b0, 1'b1, 1, 1'b1);

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    check_all_zero("reset_state");
    do_reset();

    for (int i = 0; i < NVEC; i++) begin
      check($sformatf("vec%0d_req", i),   int'(bus.sync_req), int'(vecs[i].exp_req));
      check($sformatf("vec%0d_pend", i),  int'(bus.pending),  vecs[i].exp_pend);
      check($sformatf("vec%0d_busy", i),  int'(bus.busy),     int'(vecs[i].exp_busy));
      check($sformatf("vec%0d_ovf", i),   int'(bus.ovf),      0);
      check($sformatf("vec%0d_toerr", i), int'(bus.to_err),   0);
      drive(vecs[i].ev, vecs[i].ack, 1'b0, 1'b0);
      step();
    end

    // Burst of 5 with an ack model answering each request 4 cycles later.
    do_reset();
    req_cnt = 0; peak = 0; rise = -100; fall = -100; seen_hi = 1'b0; seen_lo = 1'b0;
    for (int k = 0; k < 90; k++) begin
      if (int'(bus.pending) > peak) peak = int'(bus.pending);
      if (bus.sync_req) begin
        if (req_cnt > 0) check("burst_full_ack_between_reqs", int'(seen_hi && seen_lo), 1);
        req_cnt++;
        rise = k + 4; fall = k + 8; seen_hi = 1'b0; seen_lo = 1'b0;
      end
      drive(k < 5, (k >= rise) && (k < fall), 1'b0, 1'b0);
      if (bus.sync_ack) seen_hi = 1'b1;
      else if (seen_hi) seen_lo = 1'b1;
      step();
    end
    check("burst_req_count", req_cnt, 5);
    check("burst_peak_pending", peak, 4);
    check("burst_ovf", int'(bus.ovf), 0);
    check("burst_final_pending", int'(bus.pending), 0);
    check("burst_final_busy", int'(bus.busy), 0);

    // Overflow: 17 events while the first issue sits unacknowledged in WAIT_HI.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      if (k == 16) begin
        check("ovf_pend_before_drop", int'(bus.pending), 15);
        check("ovf_before_drop", int'(bus.ovf), 0);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      step();
    end
    check("ovf_pend_saturated", int'(bus.pending), 15);
    check("ovf_set", int'(bus.ovf), 1);
    check("ovf_busy", int'(bus.busy), 1);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    step();
    check("ovf_set_beats_clr", int'(bus.ovf), 1);
    check("ovf_clr_keeps_pend", int'(bus.pending), 15);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check("ovf_cleared", int'(bus.ovf), 0);
    check("ovf_clr_pend_after", int'(bus.pending), 15);

    // Timeout: one event that is never acknowledged.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    req_cyc = -1; to_cyc = -1;
    for (int k = 1; k < 200; k++) begin
      if (bus.sync_req && req_cyc < 0) req_cyc = k;
      if (bus.to_err) begin
        to_cyc = k;
        break;
      end
      step();
    end
    check("to_seen", int'(to_cyc >= 0), 1);
    check("to_req_cycle", req_cyc, 2);
    check("to_latency", to_cyc - req_cyc, TIMEOUT);
    check("to_back_idle", int'(bus.busy), 0);
    check("to_pending", int'(bus.pending), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    step();
    check("to_cleared", int'(bus.to_err), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    req_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.sync_req) req_cnt++;
      step();
    end
    check("to_no_reissue", req_cnt, 0);

    // Asynchronous reset in WAIT_LO with three events pending.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check("rst_pre_pend", int'(bus.pending), 3);
    check("rst_pre_busy", int'(bus.busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    req_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.sync_req) req_cnt++;
      step();
    end
    check("rst_no_replay", req_cnt, 0);
    check("rst_post_pend", int'(bus.pending), 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_new_ev_pend", int'(bus.pending), 1);
    step();
    check("rst_new_ev_req", int'(bus.sync_req), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
